// File: rtl/flash_sr_probe.sv
// rtl/flash_sr_probe.sv - wakes the config flash and reads SR1/SR2 over SPI mode 0
// Reports whether the masked {SR2,SR1} already equals the lock pattern.
module flash_sr_probe #(
  parameter logic [15:0] EXPECT_DATA = 16'h0000,
  parameter logic [15:0] EXPECT_MASK = 16'hFFFF,
  parameter bit          WAKEUP      = 1'b1,
  parameter int          WAKE_CYC    = 40,
  parameter int          CS_GAP      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  output logic        busy,
  output logic        rdy,
  output logic [15:0] sr_val,
  output logic        match,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_clk,
  output logic        spi_cs_n
);

  localparam logic [7:0] CMD_WAKE  = 8'hAB;
  localparam logic [7:0] CMD_SR1   = 8'h05;
  localparam logic [7:0] CMD_SR2   = 8'h35;
  localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYC - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, WAKE, WAKE_WAIT, RD1, GAP, RD2, DONE} state_t;

  state_t      state;
  logic [4:0]  phase;
  logic [7:0]  dly;
  logic [15:0] stage;
  logic [4:0]  phase_nx;
  logic        sample;
  logic [7:0]  cmd;
  logic [15:0] sr_nx;

  // phase[0] is the SPI clock level, phase[3:1] the bit index, phase[4] marks the data byte
  function automatic logic cmd_bit(input logic [7:0] c, input logic [4:0] p);
    return p[4] ? 1'b0 : c[~p[3:1]];
  endfunction

  assign phase_nx = phase + 5'd1;
  assign sample   = phase[4] & phase[0];
  assign sr_nx    = {stage[14:8], spi_miso, stage[7:0]};

  always_comb begin
    cmd = 8'h00;
    case (state)
      WAKE:    cmd = CMD_WAKE;
      RD1:     cmd = CMD_SR1;
      RD2:     cmd = CMD_SR2;
      default: cmd = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= 5'd0;
      dly      <= 8'd0;
      stage    <= 16'h0000;
      busy     <= 1'b0;
      rdy      <= 1'b0;
      sr_val   <= 16'h0000;
      match    <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            busy     <= 1'b1;
            spi_cs_n <= 1'b0;
            spi_clk  <= 1'b0;
            phase    <= 5'd0;
            if (WAKEUP) begin
              state    <= WAKE;
              spi_mosi <= CMD_WAKE[7];
            end else begin
              state    <= RD1;
              spi_mosi <= CMD_SR1[7];
            end
          end
        end
        WAKE: begin
          if (phase == 5'd15) begin
            state    <= WAKE_WAIT;
            spi_cs_n <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            dly      <= WAKE_LOAD;
          end else begin
            phase    <= phase_nx;
            spi_clk  <= phase_nx[0];
            spi_mosi <= cmd_bit(cmd, phase_nx);
          end
        end
        WAKE_WAIT: begin
          if (dly == 8'd0) begin
            state    <= RD1;
            spi_cs_n <= 1'b0;
            phase    <= 5'd0;
            spi_mosi <= CMD_SR1[7];
          end else begin
            dly <= dly - 8'd1;
          end
        end
        RD1: begin
          if (sample) stage[7:0] <= {stage[6:0], spi_miso};
          if (phase == 5'd31) begin
            state    <= GAP;
            spi_cs_n <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            dly      <= GAP_LOAD;
          end else begin
            phase    <= phase_nx;
            spi_clk  <= phase_nx[0];
            spi_mosi <= cmd_bit(cmd, phase_nx);
          end
        end
        GAP: begin
          if (dly == 8'd0) begin
            state    <= RD2;
            spi_cs_n <= 1'b0;
            phase    <= 5'd0;
            spi_mosi <= CMD_SR2[7];
          end else begin
            dly <= dly - 8'd1;
          end
        end
        RD2: begin
          if (sample) stage[15:8] <= {stage[14:8], spi_miso};
          if (phase == 5'd31) begin
            // results publish together with rdy, one cycle with CS_N already high
            state    <= DONE;
            spi_cs_n <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            busy     <= 1'b0;
            rdy      <= 1'b1;
            sr_val   <= sr_nx;
            match    <= ((sr_nx ^ EXPECT_DATA) & EXPECT_MASK) == 16'h0000;
          end else begin
            phase    <= phase_nx;
            spi_clk  <= phase_nx[0];
            spi_mosi <= cmd_bit(cmd, phase_nx);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_sr_probe.sv
// tb/tb_flash_sr_probe.sv - scoreboard bench for flash_sr_probe with a behavioural SPI flash
`timescale 1ns/1ps
module tb_flash_sr_probe;

  localparam int LAT_W = 16 + 40 + 32 + 2 + 32 + 1;
  localparam int LAT_N = 32 + 2 + 32 + 1;

  typedef struct {
    int          inst;
    int          go_cyc;
    logic [15:0] sr;
    logic        m;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  go  = 2'b00;
  logic [1:0]  busy, rdy, match, mosi, sclk, cs_n;
  logic [15:0] sr_val [2];
  logic [7:0]  sr1 [2];
  logic [7:0]  sr2 [2];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          t0;
  int          tw;
  exp_t        exp_q[$];
  logic [31:0] frame_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ed(input int i);
    return (i == 0) ? 16'h0200 : 16'h027C;
  endfunction

  function automatic logic [15:0] em(input int i);
    return (i == 0) ? 16'hFFFF : 16'hFF83;
  endfunction

  // instance 0 wakes the flash first, instance 1 goes straight to the reads
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       miso = 1'b0;
    logic [7:0] sh   = 8'h00;
    logic [7:0] fcmd = 8'h00;
    int         bitc = 0;
    int         lo_len = 0;
    int         hi_len = 0;
    int         viol = 0;
    exp_t       e;

    flash_sr_probe #(
      .EXPECT_DATA((g == 0) ? 16'h0200 : 16'h027C),
      .EXPECT_MASK((g == 0) ? 16'hFFFF : 16'hFF83),
      .WAKEUP     (g == 0),
      .WAKE_CYC   (40),
      .CS_GAP     (2)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .go      (go[g]),
      .busy    (busy[g]),
      .rdy     (rdy[g]),
      .sr_val  (sr_val[g]),
      .match   (match[g]),
      .spi_mosi(mosi[g]),
      .spi_miso(miso),
      .spi_clk (sclk[g]),
      .spi_cs_n(cs_n[g])
    );

    // flash: shift the command on rising edges, present each data bit from the rising edge on
    initial forever begin
      @(posedge sclk[g] or posedge cs_n[g]);
      if (cs_n[g]) begin
        bitc = 0;
        miso = 1'b0;
      end else begin
        bitc++;
        if (bitc <= 8) begin
          sh = {sh[6:0], mosi[g]};
          if (bitc == 8) fcmd = sh;
        end else if (bitc <= 16) begin
          if (mosi[g] !== 1'b0) viol++;
          miso = (fcmd == 8'h05) ? sr1[g][16 - bitc] :
                 (fcmd == 8'h35) ? sr2[g][16 - bitc] : 1'b0;
        end
      end
    end

    initial forever begin
      @(negedge clk);
      if (busy[g] === 1'b0 && (cs_n[g] !== 1'b1 || sclk[g] !== 1'b0 || mosi[g] !== 1'b0)) viol++;
      if (cs_n[g] === 1'b1 && (sclk[g] !== 1'b0 || mosi[g] !== 1'b0)) viol++;
      if (cs_n[g] === 1'b0) begin
        lo_len++;
        if (hi_len > 0) begin
          frame_log.push_back({8'h2, 8'h00, 16'(hi_len)});
          hi_len = 0;
        end
      end else begin
        if (lo_len > 0) begin
          frame_log.push_back({8'h1, fcmd, 16'(lo_len)});
          lo_len = 0;
        end
        if (busy[g] === 1'b1) hi_len++;
        else hi_len = 0;
      end
      if (rdy[g] === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].inst != g) begin
          chk("rdy_spurious", 32'(rdy[g]), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", 32'(cyc - e.go_cyc), 32'((g == 0) ? LAT_W : LAT_N));
          chk("sr_val", 32'(sr_val[g]), 32'(e.sr));
          chk("match", 32'(match[g]), 32'(e.m));
          chk("busy_at_rdy", 32'(busy[g]), 32'h0);
        end
      end
    end
  end

  task automatic expect_probe(input int i, input int gc);
    exp_t x;
    x.inst   = i;
    x.go_cyc = gc;
    x.sr     = {sr2[i], sr1[i]};
    x.m      = ((x.sr ^ ed(i)) & em(i)) == 16'h0000;
    exp_q.push_back(x);
  endtask

  task automatic start(input int i);
    @(negedge clk);
    go[i] = 1'b1;
    expect_probe(i, cyc);
    @(negedge clk);
    go[i] = 1'b0;
    chk("cs_low_cycle1", 32'(cs_n[i]), 32'h0);
    chk("busy_cycle1", 32'(busy[i]), 32'h1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("rdy_timeout", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_frames(input int i, input int n);
    logic [31:0] ex[$];
    for (int r = 0; r < n; r++) begin
      if (i == 0) begin
        ex.push_back({8'h1, 8'hAB, 16'd16});
        ex.push_back({8'h2, 8'h00, 16'd40});
      end
      ex.push_back({8'h1, 8'h05, 16'd32});
      ex.push_back({8'h2, 8'h00, 16'd2});
      ex.push_back({8'h1, 8'h35, 16'd32});
    end
    chk("frame_count", 32'(frame_log.size()), 32'(ex.size()));
    for (int k = 0; k < ex.size() && k < frame_log.size(); k++)
      chk($sformatf("frame%0d", k), frame_log[k], ex[k]);
    frame_log.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    sr1[0] = 8'h00; sr2[0] = 8'h02;
    sr1[1] = 8'h00; sr2[1] = 8'h02;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy[0]), 32'h0);
    chk("rst_rdy", 32'(rdy[0]), 32'h0);
    chk("rst_sr_val", 32'(sr_val[0]), 32'h0);
    chk("rst_match", 32'(match[0]), 32'h0);
    chk("rst_cs_n", 32'(cs_n), 32'h3);
    chk("rst_sclk", 32'(sclk), 32'h0);
    chk("rst_mosi", 32'(mosi), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // plain wake probe, then an SR2 value outside the lock pattern
    start(0); wait_done(); chk_frames(0, 1);
    sr2[0] = 8'h03;
    start(0); wait_done(); chk_frames(0, 1);
    sr2[0] = 8'h02;

    // go re-pulsed at cycles 5 and 60 must not restart the probe
    @(negedge clk); go[0] = 1'b1; expect_probe(0, cyc); t0 = cyc;
    @(negedge clk); go[0] = 1'b0;
    while (cyc < t0 + 5) @(negedge clk);
    go[0] = 1'b1; @(negedge clk); go[0] = 1'b0;
    while (cyc < t0 + 60) @(negedge clk);
    go[0] = 1'b1; @(negedge clk); go[0] = 1'b0;
    wait_done(); chk_frames(0, 1);

    // go held through the rdy cycle and the next: only the second cycle starts a probe
    start(0);
    tw = 0;
    while (rdy[0] !== 1'b1 && tw < 400) begin @(negedge clk); tw++; end
    go[0] = 1'b1;
    expect_probe(0, cyc + 1);
    @(negedge clk);
    @(negedge clk); go[0] = 1'b0;
    wait_done(); chk_frames(0, 2);

    // reset in RD1 while spi_clk is high
    @(negedge clk); go[0] = 1'b1; t0 = cyc;
    @(negedge clk); go[0] = 1'b0;
    while (cyc < t0 + 60) @(negedge clk);
    chk("pre_rst_sclk", 32'(sclk[0]), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_async_cs_n", 32'(cs_n[0]), 32'h1);
    chk("rst_async_sclk", 32'(sclk[0]), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("abort_sr_val", 32'(sr_val[0]), 32'h0);
    chk("abort_match", 32'(match[0]), 32'h0);
    chk("abort_busy", 32'(busy[0]), 32'h0);
    repeat (150) @(negedge clk);
    frame_log.delete();
    start(0); wait_done(); chk_frames(0, 1);

    // no-wake instance with the masked pattern and several SR1 values
    start(1); wait_done(); chk_frames(1, 1);
    sr1[1] = 8'h04;
    start(1); wait_done(); chk_frames(1, 1);
    sr1[1] = 8'h80;
    start(1); wait_done(); chk_frames(1, 1);
    sr1[1] = 8'h01; sr2[1] = 8'h42;
    start(1); wait_done(); chk_frames(1, 1);

    chk("idle_mode0_inst0", 32'(g_dut[0].viol), 32'h0);
    chk("idle_mode0_inst1", 32'(g_dut[1].viol), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
